load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-stage block directly downstream of instruction decode/execute. Accepts one decoded load/store (rv32i load/store funct3, effective address, store data, rd) per handshake and drives a single-outstanding data-memory port with byte masks. Returns sign- or zero-extended load data, or store completion, to writeback. Multi-cycle: a two-state FSM holds the request until the memory responds.

Parameters:
ADDR_W, 32, effective/memory address width
DATA_W, 32, data width; fixed at 32 (4 byte lanes)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  execute presents an op
req_ready  out  1  LSU can accept (high only in IDLE)
req_is_load  in  1  op is load (opcode op_b_load)
req_is_store  in  1  op is store (opcode op_b_store); never both with is_load
req_funct3  in  3  load_f3_t / store_f3_t encoding
req_addr  in  32  effective address rs1+imm
req_wdata  in  32  rs2 value, unshifted
req_rd  in  5  destination register
dmem_addr  out  32  word-aligned address, {req_addr[31:2],2'b00}
dmem_rmask  out  4  read byte mask, one-cycle pulse
dmem_wmask  out  4  write byte mask, one-cycle pulse
dmem_wdata  out  32  store data shifted to lane
dmem_rdata  in  32  read data, valid with dmem_resp
dmem_resp  in  1  memory completion
wb_valid  out  1  one-cycle completion pulse
wb_rd  out  5  rd for loads; 0 for stores/errors
wb_data  out  32  extended load data; 0 otherwise
wb_err  out  1  completion is an illegal/misaligned op

Behaviour:
- Reset: state=IDLE; req_ready=1 in the cycle after reset deasserts; dmem_rmask/wmask=0, dmem_addr=0, dmem_wdata=0, wb_valid=0, wb_rd=0, wb_data=0, wb_err=0.
- Accept when req_valid && req_ready (cycle N). Latch funct3, addr[1:0], rd, kind.
- Legal aligned op: cycle N+1 assert exactly one of rmask/wmask for one cycle, with dmem_addr/dmem_wdata; state->WAIT. addr/wdata held stable until resp.
- Masks: b=4'b0001<<addr[1:0]; h=4'b0011<<addr[1:0]; w=4'b1111. wdata: sb replicates byte to all lanes; sh replicates half; sw passthrough.
- WAIT: on dmem_resp (cycle M) -> cycle M+1 wb_valid=1, state->IDLE, req_ready=1 in M+1. Min accept-to-wb latency = 3 cycles with resp at N+2 (same-cycle resp as request pulse not allowed).
- Load extract: select lane by addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend, lw passthrough.
- Illegal: funct3 not in enum (load 011/110/111, store 011+), or neither kind: no memory pulse; wb_valid at N+1 with wb_err=1, wb_rd=0, wb_data=0.
- dmem_resp in IDLE ignored (covers late response after reset).
- Reset mid-WAIT: return to IDLE immediately, no wb pulse for the in-flight op.
- req_valid while !req_ready: not accepted, inputs ignored; upstream must hold.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: half at addr[0]=1 or word at addr[1:0]!=0 is misaligned -> no memory pulse, wb_valid at N+1 with wb_err=1, wb_rd=0.
- Undefined: misaligned ops are issued with offending low bits forced to zero (half: addr[0] treated 0; word: treated 00); wb_err never set for alignment.

Decomposition:
- rv32i_types gets: lsu_state_t enum {LSU_IDLE, LSU_WAIT}; struct lsu_req_t (kind, funct3, addr_lo, rd).
- Reuse existing load_f3_t, store_f3_t, rv32i_opcode.
- One sub-module: lsu_align — purely combinational mask generation, store lane replication, and load lane extraction/extension; FSM stays in load_store_unit.

Test Plan:
- lw addr=0x1004, resp after 2 cycles with rdata=0xDEADBEEF -> dmem_addr=0x1004, rmask=1111 one cycle; wb_valid, wb_rd=rd, wb_data=0xDEADBEEF.
- lb addr=0x1003, rdata=0x80FFFFFF; then lbu same -> wb_data=0xFFFFFF80, then 0x00000080; rmask=1000.
- sh addr=0x2002 wdata=0x1234ABCD -> wmask=1100, dmem_wdata=0xABCDABCD, wb_rd=0, wb_err=0.
- Back-to-back sb/lw with req_valid held high: req_ready low through WAIT, second op pulse only after first wb; exactly two wb pulses.
- Load funct3=3'b011 -> no mask pulse, wb_err=1 one cycle later; rst asserted mid-WAIT then stray dmem_resp -> no wb_valid, req_ready=1.
- lw addr=0x1002: with LSU_MISALIGN_TRAP_EN wb_err=1, no pulse; without, dmem_addr=0x1000, rmask=1111, wb_err=0.

Source files
------------

// File: rtl/rv32i_types_pkg.sv
// Shared RV32I encodings and LSU request/state types.
package rv32i_types;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NBYTES = 4;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned F3_W   = 3;

  typedef enum logic [6:0] {
    OP_B_LOAD  = 7'b0000011,
    OP_B_STORE = 7'b0100011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_t;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_f3_t;

  typedef enum logic {
    LSU_IDLE,
    LSU_WAIT
  } lsu_state_t;

  typedef enum logic [1:0] {
    LSU_KIND_NONE  = 2'd0,
    LSU_KIND_LOAD  = 2'd1,
    LSU_KIND_STORE = 2'd2
  } lsu_kind_t;

  typedef struct packed {
    lsu_kind_t        kind;
    logic [F3_W-1:0]  funct3;
    logic [1:0]       addr_lo;
    logic [RD_W-1:0]  rd;
  } lsu_req_t;

  // True when funct3 names a real load/store of the given kind.
  function automatic logic f3_legal(input lsu_kind_t kind, input logic [F3_W-1:0] f3);
    logic ok;
    ok = 1'b0;
    if (kind == LSU_KIND_LOAD) begin
      case (f3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
        default:                             ok = 1'b0;
      endcase
    end else if (kind == LSU_KIND_STORE) begin
      case (f3)
        F3_SB, F3_SH, F3_SW: ok = 1'b1;
        default:             ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic for the LSU: byte masks, store replication,
// load lane extraction and extension. Alignment policy is selected by
// LSU_MISALIGN_TRAP_EN (trap when defined, force low bits to zero otherwise).
module lsu_align
  import rv32i_types::*;
(
  input  lsu_kind_t   kind_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  mask_c,
  output logic [31:0] wdata_c,
  output logic [1:0]  addr_lo_c,
  output logic        err_c,
  input  logic [2:0]  rsp_funct3_i,
  input  logic [1:0]  rsp_addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ldata_c
);

  logic [1:0]  size;
  logic        legal;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  // Request side: legality, effective lane offset, byte mask, store data.
  always_comb begin
    size      = funct3_i[1:0];
    legal     = f3_legal(kind_i, funct3_i);
    addr_lo_c = addr_lo_i;
    err_c     = 1'b0;
    mask_c    = 4'b0000;
    wdata_c   = wdata_i;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign  = ((size == 2'b01) && addr_lo_i[0]) ||
                ((size == 2'b10) && (addr_lo_i != 2'b00));
    err_c     = !legal || misalign;
`else
    case (size)
      2'b01:   addr_lo_c = {addr_lo_i[1], 1'b0};
      2'b10:   addr_lo_c = 2'b00;
      default: addr_lo_c = addr_lo_i;
    endcase
    err_c     = !legal;
`endif
    case (size)
      2'b00: begin
        mask_c  = 4'(4'b0001 << addr_lo_c);
        wdata_c = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        mask_c  = 4'(4'b0011 << addr_lo_c);
        wdata_c = {2{wdata_i[15:0]}};
      end
      default: begin
        mask_c  = 4'b1111;
        wdata_c = wdata_i;
      end
    endcase
  end

  // Response side: pick the addressed lane and extend to 32 bits.
  always_comb begin
    lane_b  = rdata_i[{rsp_addr_lo_i, 3'b000} +: 8];
    lane_h  = rsp_addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    ldata_c = rdata_i;
    case (rsp_funct3_i)
      F3_LB:   ldata_c = {{24{lane_b[7]}}, lane_b};
      F3_LH:   ldata_c = {{16{lane_h[15]}}, lane_h};
      F3_LBU:  ldata_c = {24'h000000, lane_b};
      F3_LHU:  ldata_c = {16'h0000, lane_h};
      default: ldata_c = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store unit: accepts one op, pulses the
// data-memory port, waits for the response, returns a writeback pulse.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned half/word ops into errors.
module load_store_unit
  import rv32i_types::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_load,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_rmask,
  output logic [3:0]        dmem_wmask,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_resp,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_err
);

  lsu_state_t        state_q, state_d;
  lsu_req_t          req_q, req_d;
  logic              req_ready_q, req_ready_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [3:0]        rmask_q, rmask_d, wmask_q, wmask_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wb_valid_q, wb_valid_d, wb_err_q, wb_err_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  lsu_kind_t   kind_in;
  logic [3:0]  mask_c;
  logic [31:0] st_wdata_c, ldata_c;
  logic [1:0]  addr_lo_c;
  logic        err_c;

  assign kind_in = req_is_load  ? LSU_KIND_LOAD  :
                   req_is_store ? LSU_KIND_STORE : LSU_KIND_NONE;

  lsu_align u_align (
    .kind_i        (kind_in),
    .funct3_i      (req_funct3),
    .addr_lo_i     (req_addr[1:0]),
    .wdata_i       (req_wdata),
    .mask_c        (mask_c),
    .wdata_c       (st_wdata_c),
    .addr_lo_c     (addr_lo_c),
    .err_c         (err_c),
    .rsp_funct3_i  (req_q.funct3),
    .rsp_addr_lo_i (req_q.addr_lo),
    .rdata_i       (dmem_rdata),
    .ldata_c       (ldata_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    dmem_addr_d = dmem_addr_q;
    wdata_d     = wdata_q;
    rmask_d     = 4'b0000;
    wmask_d     = 4'b0000;
    wb_valid_d  = 1'b0;
    wb_err_d    = 1'b0;
    wb_rd_d     = 5'd0;
    wb_data_d   = '0;
    case (state_q)
      LSU_IDLE: begin
        if (req_valid && req_ready_q) begin
          if (err_c) begin
            wb_valid_d = 1'b1;
            wb_err_d   = 1'b1;
          end else begin
            req_d.kind    = kind_in;
            req_d.funct3  = req_funct3;
            req_d.addr_lo = addr_lo_c;
            req_d.rd      = req_rd;
            dmem_addr_d   = {req_addr[ADDR_W-1:2], 2'b00};
            if (kind_in == LSU_KIND_LOAD) begin
              rmask_d = mask_c;
            end else begin
              wmask_d = mask_c;
              wdata_d = st_wdata_c;
            end
            state_d = LSU_WAIT;
          end
        end
      end
      LSU_WAIT: begin
        if (dmem_resp) begin
          state_d    = LSU_IDLE;
          wb_valid_d = 1'b1;
          if (req_q.kind == LSU_KIND_LOAD) begin
            wb_rd_d   = req_q.rd;
            wb_data_d = ldata_c;
          end
        end
      end
      default: state_d = LSU_IDLE;
    endcase
    req_ready_d = (state_d == LSU_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LSU_IDLE;
      req_q       <= lsu_req_t'('0);
      req_ready_q <= 1'b1;
      dmem_addr_q <= '0;
      rmask_q     <= 4'b0000;
      wmask_q     <= 4'b0000;
      wdata_q     <= '0;
      wb_valid_q  <= 1'b0;
      wb_err_q    <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      req_ready_q <= req_ready_d;
      dmem_addr_q <= dmem_addr_d;
      rmask_q     <= rmask_d;
      wmask_q     <= wmask_d;
      wdata_q     <= wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_err_q    <= wb_err_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_rmask = rmask_q;
  assign dmem_wmask = wmask_q;
  assign dmem_wdata = wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign wb_err     = wb_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_load = 1'b0;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [4:0]  req_rd = 5'd0;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = 32'h0;
  logic        dmem_resp = 1'b0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_err;

  int checks = 0;
  int failures = 0;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_load(req_is_load), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    req_valid    = 1'b0;
    req_is_load  = 1'b0;
    req_is_store = 1'b0;
    req_funct3   = 3'b000;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    req_rd       = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({req_ready, dmem_rmask, dmem_wmask, dmem_addr, dmem_wdata, wb_valid, wb_rd, wb_data, wb_err}
        !== {1'b1, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0})
      begin failures++; $display("FAIL reset_state: got ready=%b rm=%h wm=%h addr=%h wd=%h wbv=%b rd=%0d d=%h e=%b, required ready=1 rest 0",
        req_ready, dmem_rmask, dmem_wmask, dmem_addr, dmem_wdata, wb_valid, wb_rd, wb_data, wb_err); end
    tick();
    checks++;
    if ({req_ready, dmem_rmask, dmem_wmask, wb_valid} !== {1'b1, 4'h0, 4'h0, 1'b0})
      begin failures++; $display("FAIL reset_idle: got ready=%b rm=%h wm=%h wbv=%b, required 1 0 0 0",
        req_ready, dmem_rmask, dmem_wmask, wb_valid); end
  endtask

  task automatic test_load_case(input string name, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [4:0] rd, input logic [31:0] rdata,
                                input logic [3:0] exp_mask, input logic [31:0] exp_addr,
                                input logic [31:0] exp_data);
    req_valid = 1'b1; req_is_load = 1'b1; req_is_store = 1'b0;
    req_funct3 = f3; req_addr = addr; req_wdata = 32'hFFFF_FFFF; req_rd = rd;
    tick();
    clear_req();
    checks++;
    if ({req_ready, dmem_rmask, dmem_wmask, dmem_addr, wb_valid} !== {1'b0, exp_mask, 4'h0, exp_addr, 1'b0})
      begin failures++; $display("FAIL %s_issue: got ready=%b rm=%h wm=%h addr=%h wbv=%b, required 0 %h 0 %h 0",
        name, req_ready, dmem_rmask, dmem_wmask, dmem_addr, wb_valid, exp_mask, exp_addr); end
    tick();
    checks++;
    if ({req_ready, dmem_rmask, dmem_addr, wb_valid} !== {1'b0, 4'h0, exp_addr, 1'b0})
      begin failures++; $display("FAIL %s_wait: got ready=%b rm=%h addr=%h wbv=%b, required 0 0 %h 0",
        name, req_ready, dmem_rmask, dmem_addr, wb_valid, exp_addr); end
    dmem_resp = 1'b1; dmem_rdata = rdata;
    tick();
    dmem_resp = 1'b0; dmem_rdata = 32'h0;
    checks++;
    if ({wb_valid, wb_err, wb_rd, wb_data, req_ready} !== {1'b1, 1'b0, rd, exp_data, 1'b1})
      begin failures++; $display("FAIL %s_wb: got v=%b e=%b rd=%0d d=%h ready=%b, required 1 0 %0d %h 1",
        name, wb_valid, wb_err, wb_rd, wb_data, req_ready, rd, exp_data); end
    tick();
    checks++;
    if (wb_valid !== 1'b0)
      begin failures++; $display("FAIL %s_wb_pulse: got wbv=%b, required 0", name, wb_valid); end
  endtask

  task automatic test_store_case(input string name, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] rd,
                                 input logic [3:0] exp_mask, input logic [31:0] exp_addr,
                                 input logic [31:0] exp_wdata);
    req_valid = 1'b1; req_is_load = 1'b0; req_is_store = 1'b1;
    req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
    tick();
    clear_req();
    checks++;
    if ({req_ready, dmem_rmask, dmem_wmask, dmem_addr, dmem_wdata} !== {1'b0, 4'h0, exp_mask, exp_addr, exp_wdata})
      begin failures++; $display("FAIL %s_issue: got ready=%b rm=%h wm=%h addr=%h wd=%h, required 0 0 %h %h %h",
        name, req_ready, dmem_rmask, dmem_wmask, dmem_addr, dmem_wdata, exp_mask, exp_addr, exp_wdata); end
    tick();
    checks++;
    if ({dmem_wmask, dmem_addr, dmem_wdata} !== {4'h0, exp_addr, exp_wdata})
      begin failures++; $display("FAIL %s_hold: got wm=%h addr=%h wd=%h, required 0 %h %h",
        name, dmem_wmask, dmem_addr, dmem_wdata, exp_addr, exp_wdata); end
    dmem_resp = 1'b1; dmem_rdata = 32'h5555_5555;
    tick();
    dmem_resp = 1'b0; dmem_rdata = 32'h0;
    checks++;
    if ({wb_valid, wb_err, wb_rd, wb_data, req_ready} !== {1'b1, 1'b0, 5'd0, 32'h0, 1'b1})
      begin failures++; $display("FAIL %s_wb: got v=%b e=%b rd=%0d d=%h ready=%b, required 1 0 0 0 1",
        name, wb_valid, wb_err, wb_rd, wb_data, req_ready); end
  endtask

  task automatic test_err_case(input string name, input logic ld, input logic st,
                               input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
    req_valid = 1'b1; req_is_load = ld; req_is_store = st;
    req_funct3 = f3; req_addr = addr; req_wdata = 32'hA5A5_A5A5; req_rd = rd;
    tick();
    clear_req();
    checks++;
    if ({dmem_rmask, dmem_wmask, wb_valid, wb_err, wb_rd, wb_data, req_ready}
        !== {4'h0, 4'h0, 1'b1, 1'b1, 5'd0, 32'h0, 1'b1})
      begin failures++; $display("FAIL %s_err: got rm=%h wm=%h v=%b e=%b rd=%0d d=%h ready=%b, required 0 0 1 1 0 0 1",
        name, dmem_rmask, dmem_wmask, wb_valid, wb_err, wb_rd, wb_data, req_ready); end
    tick();
    checks++;
    if ({dmem_rmask, dmem_wmask, wb_valid, wb_err} !== {4'h0, 4'h0, 1'b0, 1'b0})
      begin failures++; $display("FAIL %s_after: got rm=%h wm=%h v=%b e=%b, required all 0",
        name, dmem_rmask, dmem_wmask, wb_valid, wb_err); end
  endtask

  task automatic test_back_to_back();
    int wb_cnt = 0;
    int rp = 0;
    int wp = 0;
    int wb1_cyc = -1;
    int rm_cyc = -1;
    logic pend = 1'b0;
    logic acc;
    logic [4:0]  wb1_rd = 5'h1F;
    logic [4:0]  wb2_rd = 5'd0;
    logic [31:0] wb2_data = 32'h0;
    logic [9:0]  rdy = '0;
    req_valid = 1'b1; req_is_store = 1'b1; req_is_load = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h5A; req_rd = 5'd1;
    tick();
    req_is_store = 1'b0; req_is_load = 1'b1;
    req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h0; req_rd = 5'd9;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (cyc < 10) rdy[cyc] = req_ready;
      if (wb_valid) begin
        wb_cnt++;
        if (wb_cnt == 1) begin wb1_cyc = cyc; wb1_rd = wb_rd; end
        else begin wb2_rd = wb_rd; wb2_data = wb_data; end
      end
      if (dmem_rmask != 4'h0) begin rp++; rm_cyc = cyc; end
      if (dmem_wmask != 4'h0) wp++;
      dmem_resp  = pend;
      dmem_rdata = pend ? 32'h1122_3344 : 32'h0;
      pend = ((dmem_rmask | dmem_wmask) != 4'h0);
      acc  = req_valid && req_ready;
      tick();
      if (acc) clear_req();
    end
    dmem_resp = 1'b0; dmem_rdata = 32'h0;
    clear_req();
    checks++;
    if (wb_cnt !== 2) begin failures++; $display("FAIL b2b_wb_count: got %0d, required 2", wb_cnt); end
    checks++;
    if ({wp, rp} !== {32'sd1, 32'sd1}) begin failures++; $display("FAIL b2b_pulses: got w=%0d r=%0d, required 1 1", wp, rp); end
    checks++;
    if ({wb1_cyc, rm_cyc} !== {32'sd3, 32'sd4})
      begin failures++; $display("FAIL b2b_order: got wb1=%0d rpulse=%0d, required 3 4", wb1_cyc, rm_cyc); end
    checks++;
    if ({rdy[1], rdy[2], rdy[3], rdy[4]} !== 4'b0010)
      begin failures++; $display("FAIL b2b_ready: got %b%b%b%b, required 0010", rdy[1], rdy[2], rdy[3], rdy[4]); end
    checks++;
    if ({wb1_rd, wb2_rd, wb2_data} !== {5'd0, 5'd9, 32'h1122_3344})
      begin failures++; $display("FAIL b2b_data: got rd1=%0d rd2=%0d d2=%h, required 0 9 11223344", wb1_rd, wb2_rd, wb2_data); end
  endtask

  task automatic test_reset_mid_wait();
    req_valid = 1'b1; req_is_load = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_rd = 5'd6;
    tick();
    clear_req();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dmem_resp = 1'b1; dmem_rdata = 32'h0000_FFFF;
    checks++;
    if ({req_ready, wb_valid, dmem_rmask, dmem_addr} !== {1'b1, 1'b0, 4'h0, 32'h0})
      begin failures++; $display("FAIL rst_wait_state: got ready=%b wbv=%b rm=%h addr=%h, required 1 0 0 0",
        req_ready, wb_valid, dmem_rmask, dmem_addr); end
    tick();
    dmem_resp = 1'b0; dmem_rdata = 32'h0;
    checks++;
    if ({req_ready, wb_valid} !== 2'b10)
      begin failures++; $display("FAIL rst_stray_resp: got ready=%b wbv=%b, required 1 0", req_ready, wb_valid); end
    tick();
    checks++;
    if ({req_ready, wb_valid, dmem_rmask, dmem_wmask} !== {1'b1, 1'b0, 4'h0, 4'h0})
      begin failures++; $display("FAIL rst_stray_after: got ready=%b wbv=%b rm=%h wm=%h, required 1 0 0 0",
        req_ready, wb_valid, dmem_rmask, dmem_wmask); end
  endtask

  task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
    test_err_case("mis_lw", 1'b1, 1'b0, 3'b010, 32'h1002, 5'd3);
    test_err_case("mis_sh", 1'b0, 1'b1, 3'b001, 32'h2001, 5'd3);
`else
    test_load_case("mis_lw", 3'b010, 32'h1002, 5'd3, 32'hCAFE_F00D, 4'b1111, 32'h1000, 32'hCAFE_F00D);
    test_load_case("mis_lh", 3'b001, 32'h1003, 5'd4, 32'h7FFF_0000, 4'b1100, 32'h1000, 32'h0000_7FFF);
    test_store_case("mis_sh", 3'b001, 32'h2001, 32'h0000_BEEF, 5'd2, 4'b0011, 32'h2000, 32'hBEEF_BEEF);
`endif
  endtask

  initial begin
    test_reset();
    test_load_case("lw",  3'b010, 32'h1004, 5'd5,  32'hDEAD_BEEF, 4'b1111, 32'h1004, 32'hDEAD_BEEF);
    test_load_case("lb",  3'b000, 32'h1003, 5'd7,  32'h80FF_FFFF, 4'b1000, 32'h1000, 32'hFFFF_FF80);
    test_load_case("lbu", 3'b100, 32'h1003, 5'd8,  32'h80FF_FFFF, 4'b1000, 32'h1000, 32'h0000_0080);
    test_load_case("lh",  3'b001, 32'h1002, 5'd10, 32'h8001_1234, 4'b1100, 32'h1000, 32'hFFFF_8001);
    test_load_case("lhu", 3'b101, 32'h1002, 5'd11, 32'h8001_1234, 4'b1100, 32'h1000, 32'h0000_8001);
    test_store_case("sh", 3'b001, 32'h2002, 32'h1234_ABCD, 5'd7, 4'b1100, 32'h2000, 32'hABCD_ABCD);
    test_store_case("sb", 3'b000, 32'h3001, 32'h0000_00A5, 5'd2, 4'b0010, 32'h3000, 32'hA5A5_A5A5);
    test_store_case("sw", 3'b010, 32'h3008, 32'h0BAD_F00D, 5'd2, 4'b1111, 32'h3008, 32'h0BAD_F00D);
    test_back_to_back();
    test_err_case("ld_f3_011", 1'b1, 1'b0, 3'b011, 32'h0100, 5'd4);
    test_err_case("ld_f3_110", 1'b1, 1'b0, 3'b110, 32'h0100, 5'd4);
    test_err_case("st_f3_011", 1'b0, 1'b1, 3'b011, 32'h0100, 5'd4);
    test_err_case("no_kind",   1'b0, 1'b0, 3'b010, 32'h0100, 5'd4);
    test_reset_mid_wait();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
